// File: rtl/mem_port_arbiter_if.sv
// Handshake and memory bus shared by the fetch requester, the data requester,
// the single-port memory and mem_port_arbiter.
interface mem_port_arbiter_if #(
  parameter int AW = 12,
  parameter int DW = 16
);
  logic          f_req;
  logic [AW-1:0] f_addr;
  logic          f_ack;
  logic [DW-1:0] f_rdata;

  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_ack;
  logic [DW-1:0] d_rdata;

  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic          m_read;
  logic          m_write;
  logic [DW-1:0] m_rdata;

  logic          busy;

  // Arbiter view.
  modport slave (
    input  f_req, f_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
    output f_ack, f_rdata, d_ack, d_rdata, m_addr, m_wdata, m_read, m_write, busy
  );

  // Environment view: both requesters plus the memory.
  modport master (
    output f_req, f_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
    input  f_ack, f_rdata, d_ack, d_rdata, m_addr, m_wdata, m_read, m_write, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port memory between instruction fetch (F)
// and load/store (D); each access holds its strobe MEM_LAT cycles, then acks for one.
module mem_port_arbiter #(
  parameter int AW      = 12,
  parameter int DW      = 16,
  parameter int MEM_LAT = 2
) (
  input  logic               clk,
  input  logic               rst,
  mem_port_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [2:0] CNT_INIT = 3'(MEM_LAT - 1);

  state_t        state_q,   state_d;
  logic [2:0]    cnt_q,     cnt_d;
  logic          last_d_q,  last_d_d;   // 1: D was the last completed grant
  logic          gnt_d_q,   gnt_d_d;    // 1: current access belongs to D
  logic [AW-1:0] m_addr_q,  m_addr_d;
  logic [DW-1:0] m_wdata_q, m_wdata_d;
  logic          m_read_q,  m_read_d;
  logic          m_write_q, m_write_d;
  logic          f_ack_q,   f_ack_d;
  logic          d_ack_q,   d_ack_d;
  logic [DW-1:0] f_rdata_q, f_rdata_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;
  logic          busy_q,    busy_d;
  logic          pick_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_d_d  = last_d_q;
    gnt_d_d   = gnt_d_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    m_read_d  = m_read_q;
    m_write_d = m_write_q;
    f_ack_d   = 1'b0;
    d_ack_d   = 1'b0;
    f_rdata_d = f_rdata_q;
    d_rdata_d = d_rdata_q;
    pick_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.f_req || bus.d_req) begin
          // On a tie the requester that did not win last time goes first.
          pick_d    = (bus.f_req && bus.d_req) ? !last_d_q : bus.d_req;
          gnt_d_d   = pick_d;
          m_addr_d  = pick_d ? bus.d_addr : bus.f_addr;
          if (pick_d) m_wdata_d = bus.d_wdata;
          m_read_d  = !(pick_d && bus.d_we);
          m_write_d = pick_d && bus.d_we;
          cnt_d     = CNT_INIT;
          state_d   = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q != 3'd0) begin
          cnt_d = cnt_q - 3'd1;
        end else begin
          if (!gnt_d_q)        f_rdata_d = bus.m_rdata;
          else if (!m_write_q) d_rdata_d = bus.m_rdata;
          m_read_d  = 1'b0;
          m_write_d = 1'b0;
          f_ack_d   = !gnt_d_q;
          d_ack_d   = gnt_d_q;
          last_d_d  = gnt_d_q;
          state_d   = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      last_d_q  <= 1'b1;
      gnt_d_q   <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      m_read_q  <= 1'b0;
      m_write_q <= 1'b0;
      f_ack_q   <= 1'b0;
      d_ack_q   <= 1'b0;
      f_rdata_q <= '0;
      d_rdata_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_d_q  <= last_d_d;
      gnt_d_q   <= gnt_d_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      m_read_q  <= m_read_d;
      m_write_q <= m_write_d;
      f_ack_q   <= f_ack_d;
      d_ack_q   <= d_ack_d;
      f_rdata_q <= f_rdata_d;
      d_rdata_q <= d_rdata_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.m_addr  = m_addr_q;
  assign bus.m_wdata = m_wdata_q;
  assign bus.m_read  = m_read_q;
  assign bus.m_write = m_write_q;
  assign bus.f_ack   = f_ack_q;
  assign bus.d_ack   = d_ack_q;
  assign bus.f_rdata = f_rdata_q;
  assign bus.d_rdata = d_rdata_q;
  assign bus.busy    = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: MEM_LAT=2 and MEM_LAT=1 instances, each with its own
// memory, checked every cycle against a timeline model of each access.
module tb_mem_port_arbiter;
  localparam int AW = 12;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst;
  logic preload;
  always #5 clk = ~clk;

  logic          f_req [2];
  logic [AW-1:0] f_addr [2];
  logic          d_req [2];
  logic          d_we [2];
  logic [AW-1:0] d_addr [2];
  logic [DW-1:0] d_wdata [2];

  logic          f_ack_o [2];
  logic          d_ack_o [2];
  logic          m_read_o [2];
  logic          m_write_o [2];
  logic          busy_o [2];
  logic [AW-1:0] m_addr_o [2];
  logic [DW-1:0] m_wdata_o [2];
  logic [DW-1:0] f_rdata_o [2];
  logic [DW-1:0] d_rdata_o [2];

  int vectors = 0;
  int miscompares = 0;

  function automatic logic [DW-1:0] init_val(input int unsigned a);
    if (a == 32'h010) return 16'hABCD;
    return 16'(a * 40503 + 32'h1357);
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 2 : 1;
    mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();
    mem_port_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(LAT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
    );
    logic [DW-1:0] mem [4096];
    always @(posedge clk) begin
      if (preload) begin
        for (int i = 0; i < 4096; i++) mem[i] <= init_val(i);
      end else if (bus.m_write) begin
        mem[bus.m_addr] <= bus.m_wdata;
      end
    end
    assign bus.m_rdata  = mem[bus.m_addr];
    assign bus.f_req    = f_req[g];
    assign bus.f_addr   = f_addr[g];
    assign bus.d_req    = d_req[g];
    assign bus.d_we     = d_we[g];
    assign bus.d_addr   = d_addr[g];
    assign bus.d_wdata  = d_wdata[g];
    assign f_ack_o[g]   = bus.f_ack;
    assign d_ack_o[g]   = bus.d_ack;
    assign m_read_o[g]  = bus.m_read;
    assign m_write_o[g] = bus.m_write;
    assign busy_o[g]    = bus.busy;
    assign m_addr_o[g]  = bus.m_addr;
    assign m_wdata_o[g] = bus.m_wdata;
    assign f_rdata_o[g] = bus.f_rdata;
    assign d_rdata_o[g] = bus.d_rdata;
  end

  // Model: each access is a timeline, t = cycles since the grant cycle.
  bit            md_act [2];
  int unsigned   md_t [2];
  bit            md_who [2];   // 1 = D
  bit            md_we [2];
  bit            md_last [2];  // 1 = D
  logic [AW-1:0] md_addr [2];
  logic [DW-1:0] md_wd [2];
  logic [DW-1:0] md_frd [2];
  logic [DW-1:0] md_drd [2];
  logic [DW-1:0] mmem [2][4096];

  function automatic int unsigned lat_of(input int k);
    return (k == 0) ? 2 : 1;
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      int unsigned lat;
      lat = lat_of(k);
      if (preload) for (int i = 0; i < 4096; i++) mmem[k][i] = init_val(i);
      else if (md_act[k] && md_t[k] <= lat && md_who[k] && md_we[k]) mmem[k][md_addr[k]] = md_wd[k];
      if (rst) begin
        md_act[k] = 0; md_t[k] = 0; md_last[k] = 1;
        md_frd[k] = '0; md_drd[k] = '0; md_addr[k] = '0; md_wd[k] = '0;
        md_who[k] = 0; md_we[k] = 0;
      end else if (!md_act[k]) begin
        if (f_req[k] || d_req[k]) begin
          md_who[k] = (f_req[k] && d_req[k]) ? !md_last[k] : d_req[k];
          md_act[k] = 1;
          md_t[k] = 1;
          md_addr[k] = md_who[k] ? d_addr[k] : f_addr[k];
          md_we[k] = md_who[k] && d_we[k];
          if (md_who[k]) md_wd[k] = d_wdata[k];
        end
      end else begin
        md_t[k] = md_t[k] + 1;
        if (md_t[k] == lat + 1) begin
          if (!md_who[k]) md_frd[k] = mmem[k][md_addr[k]];
          else if (!md_we[k]) md_drd[k] = mmem[k][md_addr[k]];
          md_last[k] = md_who[k];
        end else if (md_t[k] == lat + 2) begin
          md_act[k] = 0;
        end
      end
    end
  end

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s dut%0d: got 0x%0h expected 0x%0h at %0t", nm, k, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < 2; k++) begin
      int unsigned lat;
      bit strobe, ackc;
      lat = lat_of(k);
      strobe = md_act[k] && md_t[k] <= lat;
      ackc = md_act[k] && md_t[k] == lat + 1;
      chk("busy",    k, busy_o[k],    md_act[k]);
      chk("m_read",  k, m_read_o[k],  strobe && !md_we[k]);
      chk("m_write", k, m_write_o[k], strobe && md_we[k]);
      chk("f_ack",   k, f_ack_o[k],   ackc && !md_who[k]);
      chk("d_ack",   k, d_ack_o[k],   ackc && md_who[k]);
      chk("m_addr",  k, m_addr_o[k],  md_addr[k]);
      chk("m_wdata", k, m_wdata_o[k], md_wd[k]);
      chk("f_rdata", k, f_rdata_o[k], md_frd[k]);
      chk("d_rdata", k, d_rdata_o[k], md_drd[k]);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    compare_all();
  endtask

  function automatic logic [AW-1:0] rnd_addr();
    return ($urandom_range(0, 15) == 0) ? 12'h3FF : 12'($urandom_range(0, 31));
  endfunction

  task automatic rand_drive();
    for (int k = 0; k < 2; k++) begin
      if (f_ack_o[k]) f_req[k] = 0;
      else if (f_req[k]) begin
        if ($urandom_range(0, 15) == 0) f_req[k] = 0;
        else if ($urandom_range(0, 7) == 0) f_addr[k] = rnd_addr();
      end else if ($urandom_range(0, 1) == 1) begin
        f_req[k] = 1; f_addr[k] = rnd_addr();
      end
      if (d_ack_o[k]) d_req[k] = 0;
      else if (d_req[k]) begin
        if ($urandom_range(0, 15) == 0) d_req[k] = 0;
        else if ($urandom_range(0, 7) == 0) begin
          d_addr[k] = rnd_addr(); d_we[k] = 1'($urandom_range(0, 1)); d_wdata[k] = 16'($urandom);
        end
      end else if ($urandom_range(0, 1) == 1) begin
        d_req[k] = 1; d_addr[k] = rnd_addr(); d_we[k] = 1'($urandom_range(0, 1)); d_wdata[k] = 16'($urandom);
      end
    end
    rst = ($urandom_range(0, 149) == 0);
  endtask

  task automatic clear_inputs();
    for (int k = 0; k < 2; k++) begin
      f_req[k] = 0; f_addr[k] = '0; d_req[k] = 0; d_we[k] = 0; d_addr[k] = '0; d_wdata[k] = '0;
    end
  endtask

  initial begin
    rst = 1; preload = 1;
    clear_inputs();
    tick();
    // Reset state.
    for (int k = 0; k < 2; k++) begin
      chk("rst_busy", k, busy_o[k], 0);
      chk("rst_m_read", k, m_read_o[k], 0);
      chk("rst_f_ack", k, f_ack_o[k], 0);
      chk("rst_m_addr", k, m_addr_o[k], 0);
      chk("rst_f_rdata", k, f_rdata_o[k], 0);
    end
    rst = 0; preload = 0;
    tick(); tick();

    // Fetch only on both instances; DUT0 address changes mid-access.
    for (int k = 0; k < 2; k++) begin f_req[k] = 1; f_addr[k] = 12'h010; end
    tick();
    chk("f1_m_read", 0, m_read_o[0], 1);
    chk("f1_m_addr", 0, m_addr_o[0], 12'h010);
    chk("l1_m_read", 1, m_read_o[1], 1);
    f_addr[0] = 12'h3FF;
    tick();
    chk("f2_m_read", 0, m_read_o[0], 1);
    chk("f2_m_addr_stable", 0, m_addr_o[0], 12'h010);
    chk("l1_f_ack", 1, f_ack_o[1], 1);
    chk("l1_f_rdata", 1, f_rdata_o[1], 16'hABCD);
    chk("l1_m_read_off", 1, m_read_o[1], 0);
    f_req[1] = 0;
    tick();
    chk("f3_f_ack", 0, f_ack_o[0], 1);
    chk("f3_f_rdata", 0, f_rdata_o[0], 16'hABCD);
    chk("f3_m_read_off", 0, m_read_o[0], 0);
    chk("l1_idle", 1, busy_o[1], 0);
    f_req[0] = 0;
    tick();
    chk("f4_busy", 0, busy_o[0], 0);
    chk("f4_f_ack", 0, f_ack_o[0], 0);

    // Data write then read back.
    d_req[0] = 1; d_we[0] = 1; d_addr[0] = 12'h020; d_wdata[0] = 16'h1234;
    tick();
    chk("w1_m_write", 0, m_write_o[0], 1);
    chk("w1_m_read", 0, m_read_o[0], 0);
    chk("w1_m_wdata", 0, m_wdata_o[0], 16'h1234);
    tick();
    chk("w2_m_write", 0, m_write_o[0], 1);
    tick();
    chk("w3_d_ack", 0, d_ack_o[0], 1);
    chk("w3_d_rdata_kept", 0, d_rdata_o[0], 0);
    d_req[0] = 0;
    tick();
    d_req[0] = 1; d_we[0] = 0;
    tick(); tick(); tick();
    chk("r_d_ack", 0, d_ack_o[0], 1);
    chk("r_d_rdata", 0, d_rdata_o[0], 16'h1234);
    d_req[0] = 0;
    tick();

    // Tie after reset, then both keep re-requesting.
    rst = 1;
    tick();
    rst = 0;
    f_req[0] = 1; d_req[0] = 1;
    for (int c = 1; c <= 16; c++) begin
      tick();
      chk("tie_f_ack", 0, f_ack_o[0], (c == 3 || c == 11));
      chk("tie_d_ack", 0, d_ack_o[0], (c == 7 || c == 15));
      f_req[0] = !f_ack_o[0];
      d_req[0] = !d_ack_o[0];
    end
    f_req[0] = 0; d_req[0] = 0;
    for (int c = 0; c < 6; c++) tick();

    // Reset during an access, then a tie must go to F.
    f_req[0] = 1; f_addr[0] = 12'h010;
    tick();
    rst = 1;
    tick();
    chk("ra_m_read", 0, m_read_o[0], 0);
    chk("ra_busy", 0, busy_o[0], 0);
    chk("ra_f_rdata", 0, f_rdata_o[0], 0);
    rst = 0;
    d_req[0] = 1; d_we[0] = 1; d_addr[0] = 12'h020; d_wdata[0] = 16'h5555;
    for (int c = 3; c <= 5; c++) begin
      tick();
      chk("ra_f_ack", 0, f_ack_o[0], (c == 5));
      chk("ra_m_write", 0, m_write_o[0], 0);
    end
    chk("ra_f_rdata_new", 0, f_rdata_o[0], 16'hABCD);
    f_req[0] = 0;
    for (int c = 6; c <= 9; c++) begin
      tick();
      chk("ra_d_ack", 0, d_ack_o[0], (c == 9));
    end
    d_req[0] = 0;
    tick();

    // Randomized traffic including occasional resets.
    for (int n = 0; n < 4000; n++) begin
      tick();
      rand_drive();
    end
    rst = 0;
    clear_inputs();
    for (int c = 0; c < 6; c++) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
